// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer: FSM state encoding and
// the divide-factor values used at reset and for rest entries.
package tone_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } state_t;

  // Smallest factor the downstream divider accepts.
  localparam int unsigned DIV_RESET = 2;
  localparam int unsigned DIV_REST  = 0;

endpackage

// File: rtl/tone_table.sv
// Note table: DEPTH x {div, dur} storage, synchronous read with one cycle of
// latency; a same-address write returns the old word (read-before-write).
module tone_table #(
  parameter int DIV_W  = 8,
  parameter int DUR_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DIV_W-1:0]  wr_div_i,
  input  logic [DUR_W-1:0]  wr_dur_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DIV_W-1:0]  rd_div_o,
  output logic [DUR_W-1:0]  rd_dur_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DIV_W+DUR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= {wr_div_i, wr_dur_i};
    {rd_div_o, rd_dur_o} <= mem[rd_addr_i];
  end

endmodule

// File: rtl/tone_sequencer.sv
// Note sequencer feeding a clock divider: walks the table, holding each
// entry's divide factor and tone enable for its duration in tick_i strobes.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int DIV_FACTOR_WIDTH = 8,
  parameter int DUR_WIDTH        = 16,
  parameter int ADDR_WIDTH       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        tick_i,
  input  logic                        wr_en_i,
  input  logic [ADDR_WIDTH-1:0]       wr_addr_i,
  input  logic [DIV_FACTOR_WIDTH-1:0] wr_div_i,
  input  logic [DUR_WIDTH-1:0]        wr_dur_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic                        loop_i,
  input  logic [ADDR_WIDTH:0]         len_i,
  output logic [DIV_FACTOR_WIDTH-1:0] div_factor_o,
  output logic                        tone_en_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [ADDR_WIDTH-1:0]       idx_o,
  output state_t                      state_o
);

  localparam logic [ADDR_WIDTH:0]         DEPTH_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]         LEN_ONE     = (ADDR_WIDTH+1)'(1);
  localparam logic [DUR_WIDTH-1:0]        DUR_ONE     = DUR_WIDTH'(1);
  localparam logic [DIV_FACTOR_WIDTH-1:0] DIV_RESET_V = DIV_FACTOR_WIDTH'(DIV_RESET);
  localparam logic [DIV_FACTOR_WIDTH-1:0] DIV_REST_V  = DIV_FACTOR_WIDTH'(DIV_REST);

  state_t                      state;
  logic                        loop_q;
  logic [ADDR_WIDTH:0]         len_q;
  logic [ADDR_WIDTH-1:0]       idx;
  logic [DUR_WIDTH-1:0]        dur_cnt;
  logic [DIV_FACTOR_WIDTH-1:0] rd_div;
  logic [DUR_WIDTH-1:0]        rd_dur;
  logic                        last_entry;

  assign last_entry = ({1'b0, idx} == (len_q - LEN_ONE));
  assign idx_o      = idx;
  assign state_o    = state;

  tone_table #(
    .DIV_W (DIV_FACTOR_WIDTH),
    .DUR_W (DUR_WIDTH),
    .ADDR_W(ADDR_WIDTH)
  ) u_table (
    .clk_i    (clk_i),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_div_i (wr_div_i),
    .wr_dur_i (wr_dur_i),
    .rd_addr_i(idx),
    .rd_div_o (rd_div),
    .rd_dur_o (rd_dur)
  );

  // start_i/stop_i are single-cycle strobes sampled every edge with no ready
  // returned; busy_o tells the caller a start would be ignored, stop always wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      div_factor_o <= DIV_RESET_V;
      tone_en_o    <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      idx          <= '0;
      loop_q       <= 1'b0;
      len_q        <= '0;
      dur_cnt      <= '0;
    end else begin
      done_o <= 1'b0;
      if (stop_i) begin
        state     <= IDLE;
        tone_en_o <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i && (len_i != '0)) begin
              loop_q <= loop_i;
              len_q  <= (len_i > DEPTH_LEN) ? DEPTH_LEN : len_i;
              idx    <= '0;
              busy_o <= 1'b1;
              state  <= FETCH;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            // Rest entries keep the previous factor so the divider never glitches.
            if (rd_div != DIV_REST_V) begin
              div_factor_o <= rd_div;
              tone_en_o    <= 1'b1;
            end else begin
              tone_en_o <= 1'b0;
            end
            dur_cnt <= (rd_dur == '0) ? DUR_ONE : rd_dur;
            state   <= PLAY;
          end
          PLAY: begin
            if (tick_i) begin
              if (dur_cnt == DUR_ONE) begin
                if (!last_entry) begin
                  idx   <= idx + 1'b1;
                  state <= FETCH;
                end else if (loop_q) begin
                  idx   <= '0;
                  state <= FETCH;
                end else begin
                  state     <= IDLE;
                  tone_en_o <= 1'b0;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                end
              end else begin
                dur_cnt <= dur_cnt - DUR_ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
